// File: rtl/sort_floats_fsm_pkg.sv
// Shared types for the sequential three-element float sorter.
// Holds the float width, the state encoding and the Inf/NaN detector.
package sort_floats_fsm_pkg;

   localparam int FLEN = 64;
   localparam int NE   = 11;

   typedef logic [FLEN-1:0] float_t;

   typedef enum logic [3:0] {
      IDLE, CMP_A, SWP_A, CMP_B, SWP_B, CMP_C, SWP_C, DONE, ERR
   } state_t;

   // All-ones exponent marks Inf or NaN; such triples are not sorted.
   function automatic logic is_err(input float_t f);
      return &f[FLEN-2 -: NE];
   endfunction

endpackage

// File: rtl/sort_floats_fsm_if.sv
// Handshake bundle between a triple producer and the sorter.
// master drives the unsorted triple, slave returns the sorted result.
interface sort_floats_fsm_if;
   import sort_floats_fsm_pkg::*;

   logic         valid_in;
   float_t [0:2] unsorted;
   logic         busy;
   logic         valid_out;
   float_t [0:2] sorted;
   logic         err;

   modport master (output valid_in, unsorted,
                   input  busy, valid_out, sorted, err);
   modport slave  (input  valid_in, unsorted,
                   output busy, valid_out, sorted, err);
endinterface

// File: rtl/sort_floats_fsm_float_gt_reg.sv
// Shared sign-magnitude "a > b" compare with a registered result.
// Optional macro SORT_FLOATS_FSM_NEG_ZERO_EN orders -0 below +0;
// without it the two zeros compare equal.
module float_gt_reg
   import sort_floats_fsm_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  float_t a,
   input  float_t b,
   output logic   gt
);

   logic            gt_c;
   logic            a_s, b_s;
   logic [FLEN-2:0] a_m, b_m;

   assign a_s = a[FLEN-1];
   assign b_s = b[FLEN-1];
   assign a_m = a[FLEN-2:0];
   assign b_m = b[FLEN-2:0];

   // Compare on raw bits: sign first, then magnitude (inverted for negatives)
   always_comb begin
      gt_c = 1'b0;
`ifdef SORT_FLOATS_FSM_NEG_ZERO_EN
      // Zeros fall through to the sign rule, so +0 > -0.
      if (a_s != b_s)
         gt_c = ~a_s;
`else
      if (a_m == '0 && b_m == '0)
         gt_c = 1'b0;
      else if (a_s != b_s)
         gt_c = ~a_s;
`endif
      else if (!a_s)
         gt_c = (a_m > b_m);
      else
         gt_c = (a_m < b_m);
   end

   // Capture the compare only while the FSM is in a compare state
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gt <= 1'b0;
      else if (en)
         gt <= gt_c;
   end

endmodule

// File: rtl/sort_floats_fsm.sv
// Sequential three-element float sorter: one shared comparator runs the
// compare-swap network (r0,r1), (r1,r2), (r0,r1) under an FSM.
// Optional macro SORT_FLOATS_FSM_NEG_ZERO_EN (see float_gt_reg).
module sort_floats_fsm
   import sort_floats_fsm_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   sort_floats_fsm_if.slave bus
);

   state_t       state;
   float_t [0:2] r;
   float_t       cmp_a, cmp_b;
   logic         cmp_en, gt, any_err;
   logic         busy_q, valid_q, err_q;
   float_t [0:2] sorted_q;

   assign any_err = is_err(bus.unsorted[0]) | is_err(bus.unsorted[1]) |
                    is_err(bus.unsorted[2]);

   // Pair B is (r1,r2); pairs A and C are both (r0,r1)
   assign cmp_a  = (state == CMP_B) ? r[1] : r[0];
   assign cmp_b  = (state == CMP_B) ? r[2] : r[1];
   assign cmp_en = (state == CMP_A) || (state == CMP_B) || (state == CMP_C);

   float_gt_reg u_gt (
      .clk (clk),
      .rst (rst),
      .en  (cmp_en),
      .a   (cmp_a),
      .b   (cmp_b),
      .gt  (gt)
   );

   // Control FSM with working and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         r        <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         sorted_q <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               // busy stays high through the valid_out cycle, so a new
               // triple is taken one cycle after the result is shown
               busy_q <= 1'b0;
               if (bus.valid_in && !busy_q) begin
                  r      <= bus.unsorted;
                  busy_q <= 1'b1;
                  state  <= any_err ? ERR : CMP_A;
               end
            end
            CMP_A: state <= SWP_A;
            SWP_A: begin
               if (gt) begin
                  r[0] <= r[1];
                  r[1] <= r[0];
               end
               state <= CMP_B;
            end
            CMP_B: state <= SWP_B;
            SWP_B: begin
               if (gt) begin
                  r[1] <= r[2];
                  r[2] <= r[1];
               end
               state <= CMP_C;
            end
            CMP_C: state <= SWP_C;
            SWP_C: begin
               if (gt) begin
                  r[0] <= r[1];
                  r[1] <= r[0];
               end
               state <= DONE;
            end
            DONE: begin
               valid_q  <= 1'b1;
               err_q    <= 1'b0;
               sorted_q <= r;
               state    <= IDLE;
            end
            ERR: begin
               // r still holds the captured input untouched
               valid_q  <= 1'b1;
               err_q    <= 1'b1;
               sorted_q <= r;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.valid_out = valid_q;
   assign bus.err       = err_q;
   assign bus.sorted    = sorted_q;

endmodule

// File: tb/tb_sort_floats_fsm.sv
// Directed + table-driven bench for sort_floats_fsm, with a real-valued
// reference sort for a random sweep over special and ordinary values.
module tb_sort_floats_fsm;
   import sort_floats_fsm_pkg::*;

   typedef float_t [0:2] trip_t;
   typedef struct {
      string name;
      trip_t in;
      trip_t exp;
      logic  err;
      int    lat;
   } vec_t;

   localparam float_t P0    = 64'h0000_0000_0000_0000;
   localparam float_t N0    = 64'h8000_0000_0000_0000;
   localparam float_t ONE   = 64'h3FF0_0000_0000_0000;
   localparam float_t TWO   = 64'h4000_0000_0000_0000;
   localparam float_t THREE = 64'h4008_0000_0000_0000;
   localparam float_t M1    = 64'hBFF0_0000_0000_0000;
   localparam float_t M2    = 64'hC000_0000_0000_0000;
   localparam float_t M3    = 64'hC008_0000_0000_0000;
   localparam float_t P234  = 64'h4002_B851_EB85_1EB8;
   localparam float_t M234  = 64'hC002_B851_EB85_1EB8;
   localparam float_t K560  = 64'h4121_1700_0000_0000;
   localparam float_t E8M7  = 64'h3EAA_D7F2_9ABC_AF48;
   localparam float_t ME8M7 = 64'hBEAA_D7F2_9ABC_AF48;
   localparam float_t PINF  = 64'h7FF0_0000_0000_0000;
   localparam float_t NINF  = 64'hFFF0_0000_0000_0000;
   localparam float_t NAN1  = 64'h7FF1_2345_6789_ABCD;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sort_floats_fsm_if bus();

   sort_floats_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30 && bus.busy !== 1'b0; i++) @(negedge clk);
      chk("wait_idle_busy", bus.busy, 1'b0);
   endtask

   // Counts valid_out pulses over n cycles (sampled after each edge)
   task automatic count_pulses(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (bus.valid_out === 1'b1) cnt++;
      end
   endtask

   // Launch a triple; lat = edges after acceptance until valid_out is seen
   task automatic run_txn(input trip_t v, output trip_t got, output logic ge,
                          output int lat, output logic busy_after, output logic vo_after);
      wait_idle();
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.unsorted = v;
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      busy_after = bus.busy;
      lat = -1;
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (bus.valid_out === 1'b1) begin
            lat = k;
            break;
         end
      end
      got = bus.sorted;
      ge  = bus.err;
      @(posedge clk); #1;
      vo_after = bus.valid_out;
   endtask

   // Reference ordering on real values; -0 below +0 only with the macro
   function automatic logic mlt(input float_t a, input float_t b);
      real ra, rb;
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      if (ra < rb) return 1'b1;
`ifdef SORT_FLOATS_FSM_NEG_ZERO_EN
      if (ra == rb && a[63] && !b[63]) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic special(input float_t f);
      return f[62:52] == 11'h7FF;
   endfunction

   vec_t  tbl [7];
   trip_t got, e, rin;
   logic  ge, ba, va;
   int    lat, cnt;
   float_t pool [14];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{"basic",   {K560, ONE, M234},  {M234, ONE, K560},  1'b0, 7};
`ifdef SORT_FLOATS_FSM_NEG_ZERO_EN
      tbl[1] = '{"zeros",   {P0, N0, E8M7},     {N0, P0, E8M7},     1'b0, 7};
`else
      tbl[1] = '{"zeros",   {P0, N0, E8M7},     {P0, N0, E8M7},     1'b0, 7};
`endif
      tbl[2] = '{"nan",     {ONE, NAN1, P234},  {ONE, NAN1, P234},  1'b1, 1};
      tbl[3] = '{"ninf",    {NINF, P0, ONE},    {NINF, P0, ONE},    1'b1, 1};
      tbl[4] = '{"sorted",  {ONE, TWO, THREE},  {ONE, TWO, THREE},  1'b0, 7};
      tbl[5] = '{"neg",     {M1, M2, M3},       {M3, M2, M1},       1'b0, 7};
      tbl[6] = '{"mixed",   {E8M7, ME8M7, P0},  {ME8M7, P0, E8M7},  1'b0, 7};

      pool = '{P0, N0, PINF, NINF, 64'h7FF8_0000_0000_0000, 64'hFFF8_0000_0000_0000,
               ONE, M1, P234, M234, K560, 64'hC121_1700_0000_0000, E8M7, ME8M7};

      rst = 1'b1;
      bus.valid_in = 1'b0;
      bus.unsorted = '0;
      #12;
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_valid", bus.valid_out, 1'b0);
      chk("reset_sorted", bus.sorted, '0);
      chk("reset_err", bus.err, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 7; i++) begin
         run_txn(tbl[i].in, got, ge, lat, ba, va);
         chk({tbl[i].name, "_sorted"}, got, tbl[i].exp);
         chk({tbl[i].name, "_err"}, ge, tbl[i].err);
         chk({tbl[i].name, "_lat"}, lat, tbl[i].lat);
         chk({tbl[i].name, "_busy"}, ba, 1'b1);
         chk({tbl[i].name, "_pulse"}, va, 1'b0);
      end

      // valid_in during busy is dropped
      wait_idle();
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.unsorted = {TWO, ONE, P0};
      @(negedge clk);
      bus.valid_in = 1'b0;
      repeat (2) @(negedge clk);
      bus.valid_in = 1'b1;
      bus.unsorted = {THREE, TWO, ONE};
      @(negedge clk);
      bus.valid_in = 1'b0;
      lat = 0;
      for (int k = 0; k < 20 && bus.valid_out !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      chk("drop_valid", bus.valid_out, 1'b1);
      chk("drop_sorted", bus.sorted, {P0, ONE, TWO});
      count_pulses(15, cnt);
      chk("drop_no_extra", cnt, 0);
      run_txn({THREE, TWO, ONE}, got, ge, lat, ba, va);
      chk("after_drop_sorted", got, {ONE, TWO, THREE});
      chk("after_drop_lat", lat, 7);

      // Reset mid-transaction aborts without a result
      wait_idle();
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.unsorted = {TWO, ONE, P0};
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_valid", bus.valid_out, 1'b0);
      chk("abort_sorted", bus.sorted, '0);
      chk("abort_err", bus.err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      count_pulses(12, cnt);
      chk("abort_no_valid", cnt, 0);
      run_txn({TWO, TWO, M1}, got, ge, lat, ba, va);
      chk("post_abort_sorted", got, {M1, TWO, TWO});
      chk("post_abort_err", ge, 1'b0);

      // Random sweep against the real-valued model
      for (int n = 0; n < 40; n++) begin
         logic xerr;
         for (int j = 0; j < 3; j++) rin[j] = pool[$urandom_range(13, 0)];
         xerr = special(rin[0]) | special(rin[1]) | special(rin[2]);
         e = rin;
         if (!xerr) begin
            for (int i = 1; i < 3; i++)
               for (int j = i; j > 0; j--)
                  if (mlt(e[j], e[j-1])) begin
                     float_t t;
                     t = e[j]; e[j] = e[j-1]; e[j-1] = t;
                  end
         end
         run_txn(rin, got, ge, lat, ba, va);
         chk("rand_sorted", got, e);
         chk("rand_err", ge, xerr);
         chk("rand_lat", lat, xerr ? 1 : 7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
